instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Registered, parametrised instruction decode stage for the 19-bit CPU, placed between fetch and the register-file/ALU stage. Accepts one instruction per cycle through a valid/ready handshake and holds the decoded fields in an output register under backpressure. Supports pipeline flush and flags illegal opcodes. Produces per-instruction register-use qualifiers for the hazard unit and keeps a retired-decode counter.

Parameters:
IW, 19, instruction width; must equal OPW + 3*RW + ALUW
OPW, 4, opcode field width
RW, 4, register specifier width
ALUW, 3, ALU type field width
JW, 11, jump/call target width, taken from instr[JW-1:0]
MW, 8, branch offset / memory address width, taken from instr[MW-1:0]
COUNT_W, 16, decode counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
instr  in  IW  raw instruction
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
opcode  out  OPW  instr[IW-1 -: OPW]
rs1, rs2, rd  out  RW each  register specifiers
funct2  out  2  immediate-op function
alu_type  out  ALUW  ALU operation
jump_addr, call_addr  out  JW each  absolute targets
branch_addr, mem_addr  out  MW each  offsets/addresses
rs1_used, rs2_used, rd_we  out  1 each  hazard qualifiers
illegal  out  1  opcode not in the defined set
decode_count  out  COUNT_W  completed output handshakes

Behaviour:
- Field slices: A = instr[IW-OPW-1 -: RW], B = instr[IW-OPW-RW-1 -: RW], C = instr[ALUW+RW-1 -: RW], F = instr[IW-OPW-RW-1 -: 2], L = instr[ALUW-1:0]. Defaults: A=[14:11], B=[10:7], C=[6:3], F=[10:9], L=[2:0].
- Per-opcode decode. Fields not listed are 0; qualifiers not listed are 0:
  - 0001 R: rs1=A, rs2=B, rd=C, alu_type=L; rs1_used, rs2_used, rd_we.
  - 0010 I: rs1=A, funct2=F, rd=C; rs1_used, rd_we.
  - 0011 jump: jump_addr=instr[JW-1:0].
  - 0100 branch: rs1=A, rs2=B, branch_addr=instr[MW-1:0]. The overlap of B and the offset is part of the ISA. rs1_used, rs2_used.
  - 0101 load: rd=A, mem_addr; rd_we.
  - 0110 store: rs1=A, mem_addr; rs1_used.
  - 0111 call: call_addr=instr[JW-1:0].
  - 1000 ret: no fields.
  - 1001 encrypt, 1010 decrypt, 1011 fft: rs1=A, mem_addr; rs1_used.
  - Any other opcode (0000, 1100-1111): illegal=1. All fields and qualifiers are 0, but opcode is still passed through.
- Handshake:
  - in_ready = !out_valid || out_ready || flush (combinational).
  - Accept = in_valid && in_ready. On accept without flush, the decoded bundle is registered and out_valid=1 on the next cycle. Latency is 1 cycle.
  - out_valid && !out_ready: all outputs hold stable and no new instruction is accepted.
  - Back-to-back transfers sustain 1 instruction/cycle.
- Flush:
  - Next cycle out_valid=0, and any instruction accepted in the same cycle is discarded.
  - Bundle fields may keep stale values while out_valid=0.
  - Flush with a simultaneous output handshake: the handshake completes and counts, then the stage is emptied.
- decode_count increments by 1 on each out_valid && out_ready cycle. It wraps modulo 2^COUNT_W and counts illegal bundles too.
- Reset (rst_n=0 at a clock edge, including mid-stream):
  - out_valid=0, decode_count=0.
  - All field outputs, qualifiers and illegal are 0.
  - in_ready during reset is 0. The first accept is possible in the cycle after rst_n returns high.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, all outputs 0, decode_count=0; first accept in the cycle after rst_n=1.
- instr=19'b0001_0011_0101_0111_010, out_ready=1 -> next cycle opcode=1, rs1=3, rs2=5, rd=7, alu_type=2, rs1_used=rs2_used=rd_we=1, illegal=0, decode_count=1 after the transfer.
- Load instr=19'b0101_1001_000_1010_0101, then out_ready=0 for 3 cycles -> rd=9, mem_addr=8'hA5, rd_we=1. Bundle is stable, in_ready=0 and the next instr is not taken until out_ready=1.
- Stream 4 instructions, assert flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, the held and incoming instructions are dropped, and decode_count is unchanged.
- Opcode 4'b0000 and 4'b1111 -> illegal=1, rs1=rs2=rd=0, out_valid=1, decode_count increments.
- COUNT_W=4, 17 consecutive transfers -> decode_count wraps to 0 after the 16th transfer and reads 1 after the 17th.

Source files
------------

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered decode stage for the 19-bit CPU with valid/ready
//               handshake, flush, illegal-opcode flag and decode counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
    parameter int IW      = 19,
    parameter int OPW     = 4,
    parameter int RW      = 4,
    parameter int ALUW    = 3,
    parameter int JW      = 11,
    parameter int MW      = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IW-1:0]      instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPW-1:0]     opcode,
    output logic [RW-1:0]      rs1,
    output logic [RW-1:0]      rs2,
    output logic [RW-1:0]      rd,
    output logic [1:0]         funct2,
    output logic [ALUW-1:0]    alu_type,
    output logic [JW-1:0]      jump_addr,
    output logic [JW-1:0]      call_addr,
    output logic [MW-1:0]      branch_addr,
    output logic [MW-1:0]      mem_addr,
    output logic               rs1_used,
    output logic               rs2_used,
    output logic               rd_we,
    output logic               illegal,
    output logic [COUNT_W-1:0] decode_count
);

    localparam int BW = OPW + 3*RW + 2 + ALUW + 2*JW + 2*MW + 4;

    localparam logic [OPW-1:0] c_OP_R    = OPW'(1);
    localparam logic [OPW-1:0] c_OP_I    = OPW'(2);
    localparam logic [OPW-1:0] c_OP_JMP  = OPW'(3);
    localparam logic [OPW-1:0] c_OP_BR   = OPW'(4);
    localparam logic [OPW-1:0] c_OP_LD   = OPW'(5);
    localparam logic [OPW-1:0] c_OP_ST   = OPW'(6);
    localparam logic [OPW-1:0] c_OP_CALL = OPW'(7);
    localparam logic [OPW-1:0] c_OP_RET  = OPW'(8);
    localparam logic [OPW-1:0] c_OP_ENC  = OPW'(9);
    localparam logic [OPW-1:0] c_OP_DEC  = OPW'(10);
    localparam logic [OPW-1:0] c_OP_FFT  = OPW'(11);

    logic [OPW-1:0]  w_op;
    logic [RW-1:0]   w_fa, w_fb, w_fc;
    logic [1:0]      w_ff;
    logic [ALUW-1:0] w_fl;

    assign w_op = instr[IW-1 -: OPW];
    assign w_fa = instr[IW-OPW-1 -: RW];
    assign w_fb = instr[IW-OPW-RW-1 -: RW];
    assign w_fc = instr[ALUW+RW-1 -: RW];
    assign w_ff = instr[IW-OPW-RW-1 -: 2];
    assign w_fl = instr[ALUW-1:0];

    logic [RW-1:0]   w_rs1, w_rs2, w_rd;
    logic [1:0]      w_funct2;
    logic [ALUW-1:0] w_alu;
    logic [JW-1:0]   w_jump, w_call;
    logic [MW-1:0]   w_branch, w_mem;
    logic            w_rs1_used, w_rs2_used, w_rd_we, w_illegal;
    logic [BW-1:0]   w_dec_bundle;

    always_comb begin
        w_rs1      = '0;
        w_rs2      = '0;
        w_rd       = '0;
        w_funct2   = '0;
        w_alu      = '0;
        w_jump     = '0;
        w_call     = '0;
        w_branch   = '0;
        w_mem      = '0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_we    = 1'b0;
        w_illegal  = 1'b0;
        case (w_op)
            c_OP_R: begin
                w_rs1 = w_fa; w_rs2 = w_fb; w_rd = w_fc; w_alu = w_fl;
                w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_rd_we = 1'b1;
            end
            c_OP_I: begin
                w_rs1 = w_fa; w_funct2 = w_ff; w_rd = w_fc;
                w_rs1_used = 1'b1; w_rd_we = 1'b1;
            end
            c_OP_JMP:  w_jump = instr[JW-1:0];
            // Branch offset deliberately overlaps the rs2 field.
            c_OP_BR: begin
                w_rs1 = w_fa; w_rs2 = w_fb; w_branch = instr[MW-1:0];
                w_rs1_used = 1'b1; w_rs2_used = 1'b1;
            end
            c_OP_LD: begin
                w_rd = w_fa; w_mem = instr[MW-1:0]; w_rd_we = 1'b1;
            end
            c_OP_ST, c_OP_ENC, c_OP_DEC, c_OP_FFT: begin
                w_rs1 = w_fa; w_mem = instr[MW-1:0]; w_rs1_used = 1'b1;
            end
            c_OP_CALL: w_call = instr[JW-1:0];
            c_OP_RET:  ;
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_dec_bundle = {w_op, w_rs1, w_rs2, w_rd, w_funct2, w_alu,
                           w_jump, w_call, w_branch, w_mem,
                           w_rs1_used, w_rs2_used, w_rd_we, w_illegal};

    logic               out_valid_q, out_valid_d;
    logic [BW-1:0]      bundle_q, bundle_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               w_accept, w_out_fire;

    // Reset also holds off fetch so nothing is accepted while rst_n is low.
    assign in_ready   = rst_n && (!out_valid_q || out_ready || flush);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        count_d     = count_q + COUNT_W'(w_out_fire);
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            bundle_d    = w_dec_bundle;
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            count_q     <= count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign decode_count = count_q;
    assign {opcode, rs1, rs2, rd, funct2, alu_type, jump_addr, call_addr,
            branch_addr, mem_addr, rs1_used, rs2_used, rd_we, illegal} = bundle_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode_stage
// Description : Scoreboard bench for instr_decode_stage (default and 4-bit
//               counter instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

    localparam int BW = 63;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [18:0] instr;

    logic        in_ready, out_valid, rs1_used, rs2_used, rd_we, illegal;
    logic [3:0]  opcode, rs1, rs2, rd;
    logic [1:0]  funct2;
    logic [2:0]  alu_type;
    logic [10:0] jump_addr, call_addr;
    logic [7:0]  branch_addr, mem_addr;
    logic [15:0] decode_count;

    logic        in_ready4, out_valid4, rs1_used4, rs2_used4, rd_we4, illegal4;
    logic [3:0]  opcode4, rs14, rs24, rd4;
    logic [1:0]  funct24;
    logic [2:0]  alu_type4;
    logic [10:0] jump_addr4, call_addr4;
    logic [7:0]  branch_addr4, mem_addr4;
    logic [3:0]  decode_count4;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .funct2(funct2),
        .alu_type(alu_type), .jump_addr(jump_addr), .call_addr(call_addr),
        .branch_addr(branch_addr), .mem_addr(mem_addr), .rs1_used(rs1_used),
        .rs2_used(rs2_used), .rd_we(rd_we), .illegal(illegal),
        .decode_count(decode_count)
    );

    instr_decode_stage #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .instr(instr), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
        .opcode(opcode4), .rs1(rs14), .rs2(rs24), .rd(rd4), .funct2(funct24),
        .alu_type(alu_type4), .jump_addr(jump_addr4), .call_addr(call_addr4),
        .branch_addr(branch_addr4), .mem_addr(mem_addr4), .rs1_used(rs1_used4),
        .rs2_used(rs2_used4), .rd_we(rd_we4), .illegal(illegal4),
        .decode_count(decode_count4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written against the fixed 19-bit field layout.
    function automatic logic [BW-1:0] model(input logic [18:0] i);
        logic [3:0] op, r1, r2, rdd;
        logic [1:0] f2;
        logic [2:0] al;
        logic [10:0] jmp, cal;
        logic [7:0] br, mem;
        logic u1, u2, we, ill;
        op = i[18:15];
        {r1, r2, rdd, f2, al, jmp, cal, br, mem, u1, u2, we, ill} = '0;
        case (op)
            4'd1: begin r1 = i[14:11]; r2 = i[10:7]; rdd = i[6:3]; al = i[2:0];
                        u1 = 1; u2 = 1; we = 1; end
            4'd2: begin r1 = i[14:11]; f2 = i[10:9]; rdd = i[6:3]; u1 = 1; we = 1; end
            4'd3: jmp = i[10:0];
            4'd4: begin r1 = i[14:11]; r2 = i[10:7]; br = i[7:0]; u1 = 1; u2 = 1; end
            4'd5: begin rdd = i[14:11]; mem = i[7:0]; we = 1; end
            4'd6, 4'd9, 4'd10, 4'd11: begin r1 = i[14:11]; mem = i[7:0]; u1 = 1; end
            4'd7: cal = i[10:0];
            4'd8: ;
            default: ill = 1;
        endcase
        return {op, r1, r2, rdd, f2, al, jmp, cal, br, mem, u1, u2, we, ill};
    endfunction

    logic [BW-1:0] sb[$];
    logic [15:0]   exp_count = '0;
    logic          exp_zero  = 1'b1;
    logic [BW-1:0] dut_bundle;

    assign dut_bundle = {opcode, rs1, rs2, rd, funct2, alu_type, jump_addr, call_addr,
                         branch_addr, mem_addr, rs1_used, rs2_used, rd_we, illegal};

    always @(negedge clk) begin
        logic exp_ov, exp_rdy;
        exp_ov  = (sb.size() != 0);
        exp_rdy = rst_n && (!exp_ov || out_ready || flush);
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        check_eq("decode_count", 64'(decode_count), 64'(exp_count));
        check_eq("decode_count4", 64'(decode_count4), 64'(exp_count[3:0]));
        if (exp_ov)
            check_eq("bundle", 64'(dut_bundle), 64'(sb[0]));
        else if (exp_zero)
            check_eq("reset_bundle", 64'(dut_bundle), 64'd0);
        if (!rst_n) begin
            sb.delete();
            exp_count = '0;
            exp_zero  = 1'b1;
        end else begin
            if (exp_ov && out_ready) begin
                void'(sb.pop_front());
                exp_count++;
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && exp_rdy) begin
                sb.push_back(model(instr));
                exp_zero = 1'b0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    logic [15:0] cnt_before;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        instr = 19'b0001_0011_0101_0111_010;
        step(3);

        // First accept happens in the cycle after reset release.
        rst_n = 1'b1;
        step();
        check_eq("r_opcode", 64'(opcode), 64'd1);
        check_eq("r_rs1", 64'(rs1), 64'd3);
        check_eq("r_rs2", 64'(rs2), 64'd5);
        check_eq("r_rd", 64'(rd), 64'd7);
        check_eq("r_alu", 64'(alu_type), 64'd2);
        check_eq("r_quals", 64'({rs1_used, rs2_used, rd_we, illegal}), 64'b1110);
        in_valid = 1'b0;
        step();
        check_eq("r_count", 64'(decode_count), 64'd1);

        // Load held under backpressure; a queued instruction must wait.
        instr = 19'b0101_1001_000_1010_0101; in_valid = 1'b1; out_ready = 1'b0;
        step();
        instr = 19'b0110_0010_000_0001_0001;
        step(3);
        check_eq("ld_rd", 64'(rd), 64'd9);
        check_eq("ld_mem", 64'(mem_addr), 64'hA5);
        check_eq("ld_we", 64'(rd_we), 64'd1);
        check_eq("ld_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step(2);
        in_valid = 1'b0;
        step();

        // Stream then flush while stalled.
        for (int k = 0; k < 4; k++) begin
            instr = {4'(k + 1), 15'($urandom)}; in_valid = 1'b1;
            step();
        end
        out_ready = 1'b0;
        cnt_before = decode_count;
        flush = 1'b1; instr = 19'b0010_0001_010_0011_000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_count", 64'(decode_count), 64'(cnt_before));
        out_ready = 1'b1;
        step();

        // Illegal opcodes.
        instr = {4'b0000, 15'h7FFF}; in_valid = 1'b1;
        step();
        check_eq("ill0", 64'({illegal, rs1, rs2, rd}), 64'h1000);
        instr = {4'b1111, 15'h5A5A};
        step();
        check_eq("ill15", 64'({illegal, rs1, rs2, rd}), 64'h1000);
        check_eq("ill15_op", 64'(opcode), 64'hF);
        in_valid = 1'b0;
        step();

        // Counter wrap on the 4-bit instance.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            instr = {4'(k % 12), 15'($urandom)};
            step();
        end
        check_eq("wrap16", 64'(decode_count4), 64'd0);
        in_valid = 1'b0;
        step();
        check_eq("wrap17", 64'(decode_count4), 64'd1);
        check_eq("wrap17_full", 64'(decode_count), 64'd17);

        // Random traffic with flushes and one mid-stream reset.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            instr     = 19'($urandom);
            rst_n     = (k != 200);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
